seq_magnitude_comparator: RTL
=============================

Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator; generalises the fixed 4-bit combinational comparator to WIDTH-bit operands. Operands are examined one SLICE-bit slice per clock, most significant slice first, with early termination on the first differing slice. Supports unsigned and two's-complement modes. Uses a start/busy/done handshake. Sits beside the Decimal2BCD datapath as the shared compare resource for wide operands.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of SLICE.
SLICE, 4, bits compared per clock; 1 <= SLICE <= WIDTH.
NUM_SLICES, WIDTH/SLICE, derived localparam; not overridable.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request a comparison; sampled only in IDLE.
signed_mode  input  1  1 = two's-complement compare; 0 = unsigned; latched with start.
a  input  WIDTH  operand A; latched with start.
b  input  WIDTH  operand B; latched with start.
busy  output  1  high while a comparison is in progress.
done  output  1  single-cycle pulse; result valid.
greater  output  1  A > B for the last completed comparison.
equal  output  1  A == B for the last completed comparison.
smaller  output  1  A < B for the last completed comparison.
cycles  output  clog2(NUM_SLICES+1)  number of slices examined in the last comparison (1..NUM_SLICES).

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; busy, done, greater, equal, smaller = 0; cycles = 0. Reset overrides every other input.
- Reset during COMPARE aborts the comparison. No done pulse is produced; outputs return to reset values.
- States: IDLE, COMPARE. Every output is a register.
- IDLE:
  - When start=1 at edge E0: latch a, b, and signed_mode.
  - In signed mode, invert bit WIDTH-1 of both latched operands. This offset-binary mapping lets the unsigned slice compare order signed values correctly.
  - Set slice index to NUM_SLICES-1, clear greater/equal/smaller/cycles, set busy=1, and go to COMPARE.
- COMPARE, one slice per cycle:
  - Compare latched A and B slice[idx] combinationally. Increment cycles at each edge.
  - If the slices differ: set greater or smaller accordingly. At the same edge set done=1, busy=0, and go to IDLE.
  - If the slices are equal and idx==0: set equal=1, done=1, busy=0, and go to IDLE.
  - Otherwise: decrement idx and stay in COMPARE.
- Latency: if the decision is made at edge Ek (k = slices examined), done is high during the cycle after Ek. Minimum latency is 1, maximum is NUM_SLICES.
- done is high for exactly one cycle. It is cleared at the next edge unless a new decision is made at that edge, which is impossible by construction.
- Result flags:
  - After done, exactly one of greater/equal/smaller is 1.
  - The flags and cycles hold until the next start is accepted.
  - All flags are 0 while busy.
- start while busy: ignored. Operands are not re-latched. No queueing.
- start in the done cycle: the state is already IDLE, so the start is accepted. This gives back-to-back operation with no idle cycle.
- Input operands may change freely after the start edge; only the latched copies are used.
- NUM_SLICES==1 (SLICE==WIDTH): every comparison takes exactly 1 cycle.
- WIDTH not divisible by SLICE: elaboration-time error.

Decomposition:
- Include file comparator_defs.vh:
  - state encodings (ST_IDLE, ST_COMPARE)
  - a clog2 constant function used for the widths of cycles and idx.
- Sub-module slice_comparator:
  - parametrised combinational SLICE-bit unsigned compare with outputs gt/eq/lt
  - instantiated once, fed by the current slice via an indexed part-select.

Test Plan (WIDTH=16, SLICE=4):
- Unsigned, a=0x1234, b=0x1234, start 1 cycle -> busy for 4 cycles; done pulse 4 cycles after the start edge; equal=1, greater=smaller=0, cycles=4.
- Unsigned, a=0x8000, b=0x7FFF -> done 1 cycle after the start edge; greater=1, cycles=1.
- Signed, a=0x8000, b=0x7FFF -> smaller=1 (-32768 < 32767), cycles=1. Signed, a=0xFFFF, b=0xFFFE -> greater=1, cycles=4.
- Unsigned, a=0x12A0, b=0x12B0 -> smaller=1, cycles=3. Flags stay held after done; changing a/b afterwards does not alter them.
- Hold start high with new operands (0x0001 vs 0x0002) throughout the first comparison -> first result unaffected. Second comparison accepted in the done cycle; smaller=1 with cycles=4 follows with no idle cycle.
- Assert rst for 1 cycle during the 2nd COMPARE cycle of a=0x1234, b=0x1234 -> all outputs 0, no done pulse. A subsequent start completes normally with equal=1.

Source files
------------

// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding and a constant clog2 used to size the counters.
package seq_magnitude_comparator_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COMPARE = 1'b1
  } state_e;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    r = 0;
    if (value > 1) begin
      v = value - 1;
      while (v > 0) begin
        r++;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/slice_comparator.sv
// Combinational unsigned compare of one slice of the two operands.
module slice_comparator #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         gt_o,
  output logic         eq_o,
  output logic         lt_o
);

  assign gt_o = (a_i >  b_i);
  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator: walks the operands one slice per
// clock, MSB slice first, and stops at the first slice that differs.
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int SLICE      = 4,
  localparam int NUM_SLICES = WIDTH / SLICE,
  localparam int CW         = clog2(NUM_SLICES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             equal,
  output logic             smaller,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NUM_SLICES > 1) ? clog2(NUM_SLICES) : 1;

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("seq_magnitude_comparator: WIDTH must be a non-zero multiple of SLICE");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cycles_q, cycles_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              greater_q, greater_d;
  logic              equal_q, equal_d;
  logic              smaller_q, smaller_d;

  logic [SLICE-1:0]  a_slice, b_slice;
  logic              sl_gt, sl_eq, sl_lt;

  assign a_slice = a_q[int'(idx_q)*SLICE +: SLICE];
  assign b_slice = b_q[int'(idx_q)*SLICE +: SLICE];

  slice_comparator #(
    .W (SLICE)
  ) u_slice_cmp (
    .a_i  (a_slice),
    .b_i  (b_slice),
    .gt_o (sl_gt),
    .eq_o (sl_eq),
    .lt_o (sl_lt)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    cycles_d  = cycles_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    greater_d = greater_q;
    equal_d   = equal_q;
    smaller_d = smaller_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d = a;
          b_d = b;
          // Offset-binary: flipping the sign bit makes unsigned order match signed order.
          if (signed_mode) begin
            a_d[WIDTH-1] = ~a[WIDTH-1];
            b_d[WIDTH-1] = ~b[WIDTH-1];
          end
          idx_d     = IW'(NUM_SLICES - 1);
          cycles_d  = '0;
          greater_d = 1'b0;
          equal_d   = 1'b0;
          smaller_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        cycles_d = cycles_q + CW'(1);
        if (!sl_eq) begin
          greater_d = sl_gt;
          smaller_d = sl_lt;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else if (idx_q == '0) begin
          equal_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      cycles_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      smaller_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      cycles_q  <= cycles_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
      smaller_q <= smaller_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign greater = greater_q;
  assign equal   = equal_q;
  assign smaller = smaller_q;
  assign cycles  = cycles_q;

endmodule
